// File: rtl/video_pattern_pkg.sv
// video_pattern_pkg: shared 1080p geometry, colour constants and the 8-bar colour table.
//   H_ACTIVE_1080P / V_ACTIVE_1080P : active pixels per line / active lines per frame
//   BAR_RGB                         : bar colours indexed by bar number 0..7
//   dir_e                           : box travel direction along one axis
package video_pattern_pkg;
  localparam int H_ACTIVE_1080P = 1920;
  localparam int V_ACTIVE_1080P = 1080;
  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;
  localparam logic [7:0][23:0] BAR_RGB = {RGB_BLACK, RGB_BLUE, RGB_RED, RGB_MAGENTA,
                                          RGB_GREEN, RGB_CYAN, RGB_YELLOW, RGB_WHITE};
  typedef enum logic {DIR_POS, DIR_NEG} dir_e;
endpackage

// File: rtl/color_move_box_gen_if.sv
// color_move_box_gen_if: timing-stage inputs and pixel/status outputs of the box generator.
//   master : drives move_en, vs, de, active_x, active_y; observes o_rgb, box_x, box_y, frame_cnt
//   slave  : the generator side
interface color_move_box_gen_if;
  logic        move_en;
  logic        vs;
  logic        de;
  logic [15:0] active_x;
  logic [15:0] active_y;
  logic [23:0] o_rgb;
  logic [15:0] box_x;
  logic [15:0] box_y;
  logic [15:0] frame_cnt;
  modport master (output move_en, vs, de, active_x, active_y,
                  input  o_rgb, box_x, box_y, frame_cnt);
  modport slave  (input  move_en, vs, de, active_x, active_y,
                  output o_rgb, box_x, box_y, frame_cnt);
endinterface

// File: rtl/color_bar_lut.sv
// color_bar_lut: maps a pixel column to its colour-bar RGB with a constant-threshold compare chain.
//   x   : pixel column
//   rgb : colour of bar min(x / (H_ACTIVE/8), 7)
module color_bar_lut
  import video_pattern_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_1080P
) (
  input  logic [15:0] x,
  output logic [23:0] rgb
);
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0] k;
  always_comb begin
    k = '0;
    for (int i = 1; i < 8; i++) k = (x >= 16'(i * BAR_W)) ? 3'(i) : k;
    rgb = BAR_RGB[k];
  end
endmodule

// File: rtl/color_move_box_gen.sv
// color_move_box_gen: colour-bar background with a bouncing solid box, moved once per frame.
//   clk, rst_n : pixel clock, synchronous active-low reset
//   bus        : move_en/vs/de/active_x/active_y in; o_rgb (1-cycle latency), box_x, box_y, frame_cnt out
module color_move_box_gen
  import video_pattern_pkg::*;
#(
  parameter int          H_ACTIVE = H_ACTIVE_1080P,
  parameter int          V_ACTIVE = V_ACTIVE_1080P,
  parameter int          BOX_W    = 128,
  parameter int          BOX_H    = 128,
  parameter int          STEP_X   = 4,
  parameter int          STEP_Y   = 2,
  parameter logic [23:0] BOX_RGB  = 24'hFFFFFF
) (
  input logic                clk,
  input logic                rst_n,
  color_move_box_gen_if.slave bus
);
  localparam logic [16:0] X_MAX = 17'(H_ACTIVE - BOX_W);
  localparam logic [16:0] Y_MAX = 17'(V_ACTIVE - BOX_H);
  localparam logic [16:0] SX    = 17'(STEP_X);
  localparam logic [16:0] SY    = 17'(STEP_Y);
  localparam logic [16:0] BW    = 17'(BOX_W);
  localparam logic [16:0] BH    = 17'(BOX_H);
  logic        vs_d_q, vs_d_d;
  logic [15:0] box_x_q, box_x_d, box_y_q, box_y_d, frame_cnt_q, frame_cnt_d;
  dir_e        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [23:0] rgb_q, rgb_d, bar_rgb;
  logic        fs, mv, x_hit, y_hit, in_box;
  logic [16:0] bx, by, ax, ay, x_next, y_next;
  color_bar_lut #(.H_ACTIVE(H_ACTIVE)) u_lut (.x(bus.active_x), .rgb(bar_rgb));
  // Position math is widened to 17 bits so edge sums/differences never wrap.
  always_comb begin
    fs          = bus.vs & ~vs_d_q;
    mv          = fs & bus.move_en;
    bx          = {1'b0, box_x_q};
    by          = {1'b0, box_y_q};
    ax          = {1'b0, bus.active_x};
    ay          = {1'b0, bus.active_y};
    x_hit       = (dir_x_q == DIR_NEG) ? (bx <= SX) : (bx + SX >= X_MAX);
    y_hit       = (dir_y_q == DIR_NEG) ? (by <= SY) : (by + SY >= Y_MAX);
    x_next      = (dir_x_q == DIR_NEG) ? (x_hit ? '0 : bx - SX) : (x_hit ? X_MAX : bx + SX);
    y_next      = (dir_y_q == DIR_NEG) ? (y_hit ? '0 : by - SY) : (y_hit ? Y_MAX : by + SY);
    vs_d_d      = bus.vs;
    frame_cnt_d = fs ? frame_cnt_q + 16'd1 : frame_cnt_q;
    box_x_d     = mv ? x_next[15:0] : box_x_q;
    box_y_d     = mv ? y_next[15:0] : box_y_q;
    dir_x_d     = (mv && x_hit) ? ((dir_x_q == DIR_POS) ? DIR_NEG : DIR_POS) : dir_x_q;
    dir_y_d     = (mv && y_hit) ? ((dir_y_q == DIR_POS) ? DIR_NEG : DIR_POS) : dir_y_q;
    // Uses the current (pre-update) box, so an illegal fs/de overlap sees the old position.
    in_box      = (ax >= bx) && (ax < bx + BW) && (ay >= by) && (ay < by + BH);
    rgb_d       = !bus.de ? 24'h0 : in_box ? BOX_RGB : bar_rgb;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_d_q      <= 1'b0;
      box_x_q     <= '0;
      box_y_q     <= '0;
      dir_x_q     <= DIR_POS;
      dir_y_q     <= DIR_POS;
      frame_cnt_q <= '0;
      rgb_q       <= '0;
    end else begin
      vs_d_q      <= vs_d_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      frame_cnt_q <= frame_cnt_d;
      rgb_q       <= rgb_d;
    end
  end
  assign bus.o_rgb     = rgb_q;
  assign bus.box_x     = box_x_q;
  assign bus.box_y     = box_y_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_color_move_box_gen.sv
// tb_color_move_box_gen: scoreboard bench for the bouncing-box pattern generator.
module tb_color_move_box_gen;
  logic clk = 0;
  logic rst_n;
  int n_cmp = 0;
  int n_err = 0;
  logic [23:0] sb[$];
  int mx, my, mcnt;
  bit mdx, mdy;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  color_move_box_gen_if bus ();
  color_move_box_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  function automatic logic [23:0] px_exp(input bit d, input int x, input int y);
    int k;
    if (!d) return 24'h0;
    if (x >= mx && x < mx + 128 && y >= my && y < my + 128) return 24'hFFFFFF;
    k = x / 240;
    return bars[k > 7 ? 7 : k];
  endfunction
  function automatic void mdl_fs();
    mcnt = (mcnt + 1) & 16'hFFFF;
    if (!bus.move_en) return;
    if (!mdx) begin
      if (mx + 4 >= 1792) begin mx = 1792; mdx = 1; end else mx += 4;
    end else begin
      if (mx <= 4) begin mx = 0; mdx = 0; end else mx -= 4;
    end
    if (!mdy) begin
      if (my + 2 >= 952) begin my = 952; mdy = 1; end else my += 2;
    end else begin
      if (my <= 2) begin my = 0; mdy = 0; end else my -= 2;
    end
  endfunction
  function automatic void mdl_rst();
    mx = 0; my = 0; mcnt = 0; mdx = 0; mdy = 0;
  endfunction
  task automatic px(input bit d, input int x, input int y);
    bus.de = d;
    bus.active_x = 16'(x);
    bus.active_y = 16'(y);
    sb.push_back(px_exp(d, x, y));
    @(negedge clk);
    chk($sformatf("rgb(%0d,%0d,%0d)", d, x, y), 32'(bus.o_rgb), 32'(sb.pop_front()));
    bus.de = 0;
  endtask
  task automatic frame();
    bus.vs = 1;
    @(negedge clk);
    mdl_fs();
    bus.vs = 0;
    @(negedge clk);
  endtask
  task automatic chk_pos(input string tag);
    chk({tag, ".box_x"}, 32'(bus.box_x), 32'(mx));
    chk({tag, ".box_y"}, 32'(bus.box_y), 32'(my));
    chk({tag, ".frame_cnt"}, 32'(bus.frame_cnt), 32'(mcnt));
  endtask
  initial begin
    int c0;
    rst_n = 0;
    bus.move_en = 1; bus.vs = 0; bus.de = 0; bus.active_x = 0; bus.active_y = 0;
    mdl_rst();
    repeat (3) @(negedge clk);
    chk("rst.o_rgb", 32'(bus.o_rgb), 0);
    chk_pos("rst");
    rst_n = 1;
    @(negedge clk);
    chk("t1.box_x", 32'(bus.box_x), 0);
    chk("t1.box_y", 32'(bus.box_y), 0);
    px(1, 5, 5);
    chk("t1.in_box_const", 32'(bus.o_rgb), 32'h00FFFFFF);
    px(1, 300, 500);
    chk("t1.bar1_const", 32'(bus.o_rgb), 32'h00FFFF00);
    px(0, 5, 5);
    frame();
    chk("t2.box_x", 32'(bus.box_x), 4);
    chk("t2.box_y", 32'(bus.box_y), 2);
    chk("t2.frame_cnt", 32'(bus.frame_cnt), 1);
    px(1, 3, 200);
    px(1, 1900, 200);
    chk("t2.bar7_const", 32'(bus.o_rgb), 0);
    px(1, 4, 2);
    px(1, 131, 129);
    px(1, 132, 50);
    px(1, 50, 130);
    px(1, 3, 50);
    px(1, 239, 600);
    px(1, 240, 600);
    px(1, 1679, 600);
    px(1, 1680, 600);
    repeat (447) frame();
    chk("t3.box_x448", 32'(bus.box_x), 1792);
    chk_pos("t3.f448");
    px(1, 1792, 897);
    px(1, 1919, 1023);
    px(1, 1791, 900);
    frame();
    chk("t3.box_x449", 32'(bus.box_x), 1788);
    chk_pos("t3.f449");
    repeat (27) frame();
    chk("t3.box_y476", 32'(bus.box_y), 952);
    chk_pos("t3.f476");
    px(1, 1700, 1079);
    frame();
    chk("t3.box_y477", 32'(bus.box_y), 950);
    chk_pos("t3.f477");
    c0 = mcnt;
    bus.vs = 1;
    repeat (10) @(negedge clk);
    mdl_fs();
    bus.vs = 0;
    @(negedge clk);
    chk("t4.frame_cnt", 32'(bus.frame_cnt), 32'(c0 + 1));
    chk_pos("t4");
    bus.move_en = 0;
    c0 = mcnt;
    repeat (5) frame();
    chk("t5.frame_cnt", 32'(bus.frame_cnt), 32'(c0 + 5));
    chk_pos("t5");
    bus.move_en = 1;
    bus.de = 1; bus.active_x = 16'(mx); bus.active_y = 16'(my);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    bus.de = 0;
    mdl_rst();
    chk("t6.o_rgb", 32'(bus.o_rgb), 0);
    chk_pos("t6");
    frame();
    chk("t6.dir_x_pos", 32'(bus.box_x), 4);
    chk("t6.dir_y_pos", 32'(bus.box_y), 2);
    px(1, 100, 100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
